data_memory_unit: RTL
=====================

# data_memory_unit

Byte-addressed, parametrised data memory for the datapath's load/store stage. It replaces the plain word-array memory with:
- byte, halfword and word accesses, with sign or zero extension on loads;
- alignment and range checking;
- a valid/ready request port and a configurable read latency;
- a hardware clear sequence after reset, so memory contents are defined without simulation-only initialisation.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 16..4096.
- READ_LAT, 1: request-to-response latency in cycles, 1..4.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  output  1  one-cycle response pulse, one per accepted request.
- rsp_rdata  output  32  extended load data; 0 for stores and for errors.
- rsp_err  output  1  request was rejected; valid only while rsp_valid=1.

## Operation
- State machine has two states, INIT and READY.
  - reset=1 forces INIT and clears the clear pointer to 0.
  - In INIT with reset=0: each edge writes word[ptr] <= 0, then ptr <= ptr+1.
  - The edge that clears word DEPTH-1 moves the block to READY.
  - req_ready = 1 only in READY.
- Acceptance: a request is accepted at a rising edge where req_valid=1 and req_ready=1. One request per cycle at most; READY accepts back-to-back with no bubbles.
- Address decode:
  - word index = req_addr[31:2].
  - Lane: byte uses req_addr[1:0]; halfword uses req_addr[1]. Byte order is little-endian.
- Error conditions (rsp_err=1):
  - req_size=11;
  - halfword with req_addr[0]=1;
  - word with req_addr[1:0]≠00;
  - word index ≥ DEPTH.
- An errored request writes nothing and still returns a response, with rsp_rdata=0.
- Store: at the accept edge, only the selected byte lanes are written; all other lanes keep their value. The response carries rsp_rdata=0 and rsp_err=0.
- Load: the addressed word is read at the accept edge, then the selected lane is extracted and extended (per req_unsigned) to 32 bits.
  - The result travels through a READ_LAT-stage valid/data/err shift pipeline.
  - Extraction and extension may sit in any stage.
- Ordering: responses return in acceptance order. A load sees every store accepted on an earlier edge, and no store accepted on a later edge.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All pipeline valid bits are cleared.
- Clear duration: with reset low from edge E0, edges E0..E(DEPTH-1) perform the clear. req_ready goes to 1 after E(DEPTH-1), so the first accept is at E(DEPTH).
- Latency: a request accepted at edge N produces rsp_valid=1 during the cycle following edge N+READ_LAT-1.
  - With READ_LAT=1, the response appears in the cycle right after acceptance.
  - rsp_valid is high for exactly one cycle per request.
- Store write data is visible to a load accepted at edge N+1.
- Reset during READY or with requests in flight:
  - all in-flight responses are dropped, with no rsp_valid;
  - the block returns to INIT and the full clear reruns;
  - memory contents are zero afterwards.
- Reset asserted mid-INIT restarts the clear at word 0.
- Inputs are ignored while req_ready=0. There is no response backpressure; the consumer must always sink responses.

## Test plan
- Clear sequence, DEPTH=16, READ_LAT=2: release reset → req_ready first high after 16 edges; a load of word 0x3C returns 0x00000000 with rsp_err=0, two cycles after accept.
- Lanes, sign and zero extension:
  - store word 0x80FF7F01 at 0x10;
  - load byte 0x11 signed → 0x0000007F;
  - load byte 0x12 signed → 0xFFFFFFFF;
  - load half 0x12 signed → 0xFFFF80FF;
  - load half 0x12 unsigned → 0x000080FF.
- Partial store: store byte 0xAB at 0x13 over 0x80FF7F01 → load word 0x10 returns 0xABFF7F01.
- Errors:
  - half load at 0x21 → rsp_err=1, rdata=0;
  - word store at 0x22 → rsp_err=1, and a later load at 0x20 is unchanged;
  - size 11 → rsp_err=1;
  - word load at 4*DEPTH → rsp_err=1.
- Back-to-back, READ_LAT=3: store 0x12345678 at 0x40, then a load of 0x40 on the next edge → load returns 0x12345678. Responses come in order, one per cycle, with no gaps.
- Reset mid-flight: two loads in flight, assert reset for one edge → no rsp_valid for them; req_ready low for DEPTH cycles; previously written words read back 0.

Source files
------------

// File: rtl/data_memory_unit.sv
// data_memory_unit: byte-addressed data memory for the load/store stage.
// Byte/halfword/word accesses with sign/zero extension on loads, alignment
// and range checking, valid/ready request port, READ_LAT-deep response
// pipeline, and a hardware clear sweep after every reset.
module data_memory_unit #(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {INIT, READY} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_ptr;
    logic [31:0]   mem [DEPTH];

    logic          accept, err;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, rd_word, rd_shift, ld_data, in_data;

    logic [READ_LAT:1] vld_pipe, err_pipe;
    logic [31:0]       data_pipe [READ_LAT:1];

    // State register and clear pointer; reset restarts the sweep at word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                clr_ptr <= clr_ptr + AW'(1);
        end
    end

    // Next state: leave INIT on the edge that clears the last word
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            INIT:  if (clr_ptr == AW'(DEPTH - 1)) state_nxt = READY;
            READY: req_ready = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    // Request decode: error check, byte enables, lane extraction/extension
    always_comb begin
        accept = req_valid && req_ready;
        idx    = req_addr[AW+1:2];
        err    = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (req_addr[31:2] >= 30'(DEPTH));

        be        = 4'b1111;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase

        // Little-endian: shift the addressed lane down to bit 0
        rd_word  = mem[idx];
        rd_shift = rd_word >> {req_addr[1:0], 3'b000};
        case (req_size)
            2'b00:   ld_data = req_unsigned ? {24'b0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_data = req_unsigned ? {16'b0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase

        in_data = (accept && !req_we && !err) ? ld_data : 32'b0;
    end

    // Memory writes: clear sweep in INIT, lane-masked stores in READY
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[clr_ptr] <= 32'b0;
            end else if (accept && req_we && !err) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // Response shift pipeline; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            for (int i = 1; i <= READ_LAT; i++) data_pipe[i] <= 32'b0;
        end else begin
            vld_pipe[1]  <= accept;
            err_pipe[1]  <= accept && err;
            data_pipe[1] <= in_data;
            for (int i = 2; i <= READ_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                err_pipe[i]  <= err_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign rsp_valid = vld_pipe[READ_LAT];
    assign rsp_err   = err_pipe[READ_LAT];
    assign rsp_rdata = data_pipe[READ_LAT];

endmodule
